// File: rtl/input_mems_pp_if.sv
// rtl/input_mems_pp_if.sv - AXI-Stream style element stream into input_mems_pp
interface input_mems_pp_if #(
    parameter int INW    = 12,
    parameter int K_BITS = 4
);
    logic [INW-1:0]  AXIS_TDATA;
    logic            AXIS_TVALID;
    logic [K_BITS:0] AXIS_TUSER;
    logic            AXIS_TREADY;

    modport master (output AXIS_TDATA, output AXIS_TVALID, output AXIS_TUSER, input AXIS_TREADY);
    modport slave  (input AXIS_TDATA, input AXIS_TVALID, input AXIS_TUSER, output AXIS_TREADY);
endinterface

// File: rtl/input_mems_pp.sv
// rtl/input_mems_pp.sv - ping-pong A/B input memories holding up to two jobs for the compute block
// Optional first-beat legality checks and sticky protocol_err under INPUT_MEMS_PP_CHECK_EN.
module input_mems_pp #(
    parameter int  INW         = 12,
    parameter int  M           = 7,
    parameter int  N           = 9,
    parameter int  MAXK        = 8,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int A_ADDR_BITS = $clog2(M * MAXK),
    localparam int B_ADDR_BITS = $clog2(MAXK * N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input_mems_pp_if.slave                s_axis,
    output logic                          matrices_loaded,
    input  logic                          compute_finished,
    output logic [K_BITS-1:0]             K,
    input  logic [A_ADDR_BITS-1:0]        A_read_addr,
    output logic signed [INW-1:0]         A_data,
    input  logic [B_ADDR_BITS-1:0]        B_read_addr,
    output logic signed [INW-1:0]         B_data,
    output logic [1:0]                    jobs_held,
    output logic                          protocol_err
);
    localparam int CNT_BITS = ((A_ADDR_BITS > B_ADDR_BITS) ? A_ADDR_BITS : B_ADDR_BITS) + 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_LOAD_A = 2'd1, S_LOAD_B = 2'd2;

    logic [1:0]          r_state;
    logic [CNT_BITS-1:0] r_cnt;
    logic [K_BITS-1:0]   r_k, r_a_k;
    logic                r_bad, r_last_a, r_next_b;
    logic                r_q_a [2];
    logic                r_q_b [2];
    logic [K_BITS-1:0]   r_q_k [2];
    logic                r_head;
    logic [1:0]          r_jobs;
    logic [INW-1:0]      r_a_mem [2][M*MAXK];
    logic [INW-1:0]      r_b_mem [2][MAXK*N];
    logic signed [INW-1:0] r_a_data, r_b_data;

    logic                w_idle, w_hs, w_first_newa, w_first_bad, w_cur_bad, w_a_phase;
    logic [K_BITS-1:0]   w_first_uk, w_first_k, w_cur_k;
    logic [CNT_BITS-1:0] w_a_len, w_b_len;
    logic                w_a_end, w_b_end, w_wr_a, w_wr_b, w_a_done, w_b_done;
    logic                w_commit, w_pop, w_tail;

    assign w_idle       = (r_state == S_IDLE);
    assign w_hs         = s_axis.AXIS_TVALID && s_axis.AXIS_TREADY;
    assign w_first_newa = s_axis.AXIS_TUSER[0];
    assign w_first_uk   = s_axis.AXIS_TUSER[K_BITS:1];

`ifdef INPUT_MEMS_PP_CHECK_EN
    logic r_a_valid, r_err;
    assign w_first_bad  = w_first_newa ? ((w_first_uk == '0) || (int'(w_first_uk) > MAXK)) : !r_a_valid;
    assign protocol_err = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_valid <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_a_done && !w_cur_bad) r_a_valid <= 1'b1;
            if (w_hs && w_idle && w_first_bad) r_err <= 1'b1;
        end
    end
`else
    assign w_first_bad  = 1'b0;
    assign protocol_err = 1'b0;
`endif

    // A rejected job still consumes its beats, counted as if K were 1
    assign w_first_k = w_first_bad ? K_BITS'(1) : (w_first_newa ? w_first_uk : r_a_k);
    assign w_cur_k   = w_idle ? w_first_k : r_k;
    assign w_cur_bad = w_idle ? w_first_bad : r_bad;
    assign w_a_phase = w_idle ? w_first_newa : (r_state == S_LOAD_A);
    assign w_a_len   = CNT_BITS'(M) * CNT_BITS'(w_cur_k);
    assign w_b_len   = CNT_BITS'(N) * CNT_BITS'(w_cur_k);
    assign w_a_end   = (r_cnt == w_a_len - CNT_BITS'(1));
    assign w_b_end   = (r_cnt == w_b_len - CNT_BITS'(1));
    assign w_wr_a    = w_hs && w_a_phase && !w_cur_bad;
    assign w_wr_b    = w_hs && !w_a_phase && !w_cur_bad;
    assign w_a_done  = w_hs && w_a_phase && w_a_end;
    assign w_b_done  = w_hs && !w_a_phase && w_b_end;
    assign w_commit  = w_b_done && !w_cur_bad;
    assign w_pop     = compute_finished && (r_jobs != 2'd0);
    assign w_tail    = r_head ^ r_jobs[0];

    assign s_axis.AXIS_TREADY = reset && (w_idle ? (r_jobs != 2'd2) : 1'b1);
    assign matrices_loaded    = (r_jobs != 2'd0);
    assign jobs_held          = r_jobs;
    assign K                  = (r_jobs != 2'd0) ? r_q_k[r_head] : '0;
    assign A_data             = r_a_data;
    assign B_data             = r_b_data;

    // Loads only ever target the A bank not named by last_a
    always_ff @(posedge clk) begin
        if (w_wr_a) r_a_mem[~r_last_a][r_cnt[A_ADDR_BITS-1:0]] <= s_axis.AXIS_TDATA;
        if (w_wr_b) r_b_mem[r_next_b][r_cnt[B_ADDR_BITS-1:0]] <= s_axis.AXIS_TDATA;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_data <= '0;
            r_b_data <= '0;
        end else begin
            r_a_data <= r_a_mem[r_q_a[r_head]][A_read_addr];
            r_b_data <= r_b_mem[r_q_b[r_head]][B_read_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_k      <= '0;
            r_a_k    <= '0;
            r_bad    <= 1'b0;
            r_last_a <= 1'b1;
            r_next_b <= 1'b0;
            r_head   <= 1'b0;
            r_jobs   <= 2'd0;
            r_q_a[0] <= 1'b0;
            r_q_a[1] <= 1'b0;
            r_q_b[0] <= 1'b0;
            r_q_b[1] <= 1'b0;
            r_q_k[0] <= '0;
            r_q_k[1] <= '0;
        end else begin
            if (w_hs) begin
                if (w_idle) begin
                    r_k   <= w_first_k;
                    r_bad <= w_first_bad;
                end
                if (w_a_done) begin
                    r_cnt   <= '0;
                    r_state <= S_LOAD_B;
                    if (!w_cur_bad) begin
                        r_last_a <= ~r_last_a;
                        r_a_k    <= w_cur_k;
                    end
                end else if (w_b_done) begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                    if (!w_cur_bad) r_next_b <= ~r_next_b;
                end else begin
                    r_cnt   <= r_cnt + CNT_BITS'(1);
                    r_state <= w_a_phase ? S_LOAD_A : S_LOAD_B;
                end
            end
            if (w_commit) begin
                r_q_a[w_tail] <= r_last_a;
                r_q_b[w_tail] <= r_next_b;
                r_q_k[w_tail] <= w_cur_k;
            end
            if (w_pop) r_head <= ~r_head;
            if (w_commit && !w_pop)      r_jobs <= r_jobs + 2'd1;
            else if (!w_commit && w_pop) r_jobs <= r_jobs - 2'd1;
        end
    end
endmodule

// File: tb/tb_input_mems_pp.sv
// tb/tb_input_mems_pp.sv - randomized scoreboard bench for input_mems_pp (default and M=N=1 instances)
module tb_input_mems_pp;
    localparam int INW = 12, MAXK = 8, KB = 4;

    typedef struct packed {
        logic [31:0]       k;
        logic [63:0][11:0] a;
        logic [71:0][11:0] b;
    } job_t;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] tdata = '0;
    logic [4:0]  tuser = '0;
    logic        tvalid = 1'b0, cf = 1'b0, sel = 1'b0;
    logic [5:0]  a_addr = '0;
    logic [6:0]  b_addr = '0;

    input_mems_pp_if #(.INW(INW), .K_BITS(KB)) axis0 ();
    input_mems_pp_if #(.INW(INW), .K_BITS(KB)) axis1 ();
    assign axis0.AXIS_TDATA  = tdata;
    assign axis0.AXIS_TUSER  = tuser;
    assign axis0.AXIS_TVALID = tvalid & ~sel;
    assign axis1.AXIS_TDATA  = tdata;
    assign axis1.AXIS_TUSER  = tuser;
    assign axis1.AXIS_TVALID = tvalid & sel;

    logic        loaded0, loaded1, perr0, perr1;
    logic [3:0]  k0, k1;
    logic [11:0] a0, a1, b0, b1;
    logic [1:0]  jobs0, jobs1;

    input_mems_pp dut0 (
        .clk(clk), .reset(rst_n), .s_axis(axis0), .matrices_loaded(loaded0),
        .compute_finished(cf & ~sel), .K(k0), .A_read_addr(a_addr), .A_data(a0),
        .B_read_addr(b_addr), .B_data(b0), .jobs_held(jobs0), .protocol_err(perr0)
    );

    input_mems_pp #(.M(1), .N(1)) dut1 (
        .clk(clk), .reset(rst_n), .s_axis(axis1), .matrices_loaded(loaded1),
        .compute_finished(cf & sel), .K(k1), .A_read_addr(a_addr[2:0]), .A_data(a1),
        .B_read_addr(b_addr[2:0]), .B_data(b1), .jobs_held(jobs1), .protocol_err(perr1)
    );

    logic        w_tready, w_loaded, w_perr;
    logic [3:0]  w_k;
    logic [11:0] w_a, w_b;
    logic [1:0]  w_jobs;
    assign w_tready = sel ? axis1.AXIS_TREADY : axis0.AXIS_TREADY;
    assign w_loaded = sel ? loaded1 : loaded0;
    assign w_perr   = sel ? perr1 : perr0;
    assign w_k      = sel ? k1 : k0;
    assign w_a      = sel ? a1 : a0;
    assign w_b      = sel ? b1 : b0;
    assign w_jobs   = sel ? jobs1 : jobs0;

    int n_tests = 0, n_fail = 0;
    int cm = 7, cn = 9, last_k = 0;
    bit a_ok = 1'b0, bubbles = 1'b0;
    job_t jq[$];
    logic [63:0][11:0] last_a_arr = '0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_e;
    logic rd_req = 1'b0, rsp_v = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    always @(posedge clk) rsp_v <= rd_req;

    always @(negedge clk) begin
        if (rsp_v) begin
            chk("rd_queue_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("A_data", w_a, mon_e[23:12]);
                chk("B_data", w_b, mon_e[11:0]);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [11:0] d, input logic [4:0] u, input bit c);
        int t;
        if (bubbles && ($urandom_range(0, 3) == 0)) @(negedge clk);
        tdata = d; tuser = u; tvalid = 1'b1; cf = c;
        t = 0;
        while (!w_tready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("tready_timeout", w_tready, 1);
        @(negedge clk);
        tvalid = 1'b0; cf = 1'b0;
    endtask

    task automatic load_job(input bit newa, input int kin, input bit seq, input bit pop_last, input int stop_after);
        job_t j;
        int k, na, nbb;
        bit bad;
        bad = 1'b0;
`ifdef INPUT_MEMS_PP_CHECK_EN
        bad = newa ? ((kin == 0) || (kin > MAXK)) : !a_ok;
`endif
        k = bad ? 1 : (newa ? kin : last_k);
        j = '0;
        j.k = k;
        na = newa ? cm * k : 0;
        nbb = k * cn;
        if (newa) for (int i = 0; i < na; i++) j.a[i] = seq ? 12'(i + 1) : 12'($urandom);
        else j.a = last_a_arr;
        for (int i = 0; i < nbb; i++) j.b[i] = seq ? 12'(na + i + 1) : 12'($urandom);
        for (int i = 0; i < na + nbb; i++) begin
            if (stop_after >= 0 && i == stop_after) return;
            send_beat((i < na) ? j.a[i] : j.b[i - na],
                      (i == 0) ? {4'(kin), newa} : 5'($urandom),
                      pop_last && (i == na + nbb - 1));
        end
        if (!bad) begin
            if (newa) begin
                last_a_arr = j.a;
                last_k = k;
                a_ok = 1'b1;
            end
            if (pop_last && jq.size() > 0) void'(jq.pop_front());
            jq.push_back(j);
        end
    endtask

    task automatic check_status();
        chk("jobs_held", w_jobs, jq.size());
        chk("matrices_loaded", w_loaded, jq.size() > 0);
        chk("K", w_k, (jq.size() > 0) ? jq[0].k : 0);
        chk("tready_idle", w_tready, jq.size() < 2);
    endtask

    task automatic chk_reset();
        chk("rst_tready", w_tready, 0);
        chk("rst_loaded", w_loaded, 0);
        chk("rst_K", w_k, 0);
        chk("rst_jobs", w_jobs, 0);
        chk("rst_A_data", w_a, 0);
        chk("rst_B_data", w_b, 0);
        chk("rst_perr", w_perr, 0);
    endtask

    task automatic rd_one(input int aa, input int bb);
        a_addr = 6'(aa);
        b_addr = 7'(bb);
        exp_q.push_back({jq[0].a[aa], jq[0].b[bb]});
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic rd_rand(input int n);
        for (int i = 0; i < n; i++) begin
            if (jq.size() == 0) return;
            rd_one($urandom_range(0, cm * jq[0].k - 1), $urandom_range(0, cn * jq[0].k - 1));
        end
    endtask

    task automatic pop_pulse();
        cf = 1'b1;
        @(negedge clk);
        cf = 1'b0;
        if (jq.size() > 0) void'(jq.pop_front());
    endtask

    task automatic random_phase(input int iters, input bit small_k);
        int r, kk;
        bit na;
        for (int it = 0; it < iters; it++) begin
            r = $urandom_range(0, 3);
            kk = (small_k && $urandom_range(0, 1) == 1) ? 1 : $urandom_range(1, MAXK);
            na = !a_ok || ($urandom_range(0, 1) == 1);
            if (r == 0 || jq.size() == 2) pop_pulse();
            else load_job(na, kk, 1'b0, (r == 3) && (jq.size() == 1), -1);
            check_status();
            rd_rand(2);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        @(negedge clk);
        chk("tready_after_reset", w_tready, 1);

        load_job(1'b1, 2, 1'b1, 1'b0, -1);
        check_status();
        rd_one(13, 0);
        rd_rand(3);
        pop_pulse();
        check_status();

        load_job(1'b1, 3, 1'b0, 1'b0, -1);
        load_job(1'b0, 0, 1'b0, 1'b0, -1);
        check_status();
        rd_rand(3);
        pop_pulse();
        check_status();
        rd_rand(4);

        load_job(1'b1, $urandom_range(1, MAXK), 1'b0, 1'b1, -1);
        check_status();
        rd_rand(4);

        bubbles = 1'b1;
        random_phase(30, 1'b0);

        while (jq.size() > 0) pop_pulse();
        load_job(1'b1, 2, 1'b0, 1'b0, -1);
        load_job(1'b1, 4, 1'b0, 1'b0, 5);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset();
        jq.delete();
        a_ok = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_job(1'b1, 1, 1'b0, 1'b0, -1);
        check_status();
        rd_rand(3);

`ifdef INPUT_MEMS_PP_CHECK_EN
        while (jq.size() > 0) pop_pulse();
        load_job(1'b1, MAXK + 1, 1'b0, 1'b0, -1);
        chk("protocol_err_set", w_perr, 1);
        check_status();
        load_job(1'b1, 3, 1'b0, 1'b0, -1);
        check_status();
        rd_rand(3);
        chk("protocol_err_sticky", w_perr, 1);
`else
        chk("protocol_err_tied", w_perr, 0);
`endif

        while (jq.size() > 0) pop_pulse();
        repeat (2) @(negedge clk);
        sel = 1'b1;
        jq.delete();
        a_ok = 1'b0;
        last_k = 0;
        cm = 1;
        cn = 1;
        check_status();
        random_phase(30, 1'b1);

        repeat (3) @(negedge clk);
        chk("rd_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
